// File: rtl/meter_coin_input.sv
// meter_coin_input
// Conditions the four raw add-time buttons for the parking-meter counter.
// Each button is synchronized, debounced for press and release, and turned
// into a single registered credit transaction held until the meter takes it.
//
// Ports:
//   clk                           system clock, rising edge
//   reset10                       asynchronous active-high reset
//   add50/add150/add200/add500    raw asynchronous buttons, active-high
//   add_ready                     meter accepts the pending credit this cycle
//   add_valid                     credit transaction pending (registered)
//   add_amount[9:0]               credit value, 0 whenever add_valid is low
//   busy                          FSM is outside IDLE (registered)
module meter_coin_input #(
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned CNT_W      = 20
) (
  input  logic       clk,
  input  logic       reset10,
  input  logic       add50,
  input  logic       add150,
  input  logic       add200,
  input  logic       add500,
  input  logic       add_ready,
  output logic       add_valid,
  output logic [9:0] add_amount,
  output logic       busy
);

  localparam int unsigned AMT_W = 10;
  localparam int unsigned NBTN  = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUAL    = 2'd1,
    FIRE    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t            state, state_next;
  logic [NBTN-1:0]   raw, sync1, sync2;
  logic [NBTN-1:0]   sel, sel_next;
  logic [AMT_W-1:0]  amt, amt_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic              valid_next;
  logic [AMT_W-1:0]  amount_next;
  logic              busy_next;
  logic              sel_hit;
  logic              any_btn;

  // Bit order doubles as priority order: bit 0 (add50) wins.
  assign raw     = {add500, add200, add150, add50};
  assign sel_hit = |(sel & sync2);
  assign any_btn = |sync2;

  // Two-flop synchronizer per button.
  always_ff @(posedge clk or posedge reset10) begin
    if (reset10) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // State, debounce and output registers.
  always_ff @(posedge clk or posedge reset10) begin
    if (reset10) begin
      state      <= IDLE;
      sel        <= '0;
      amt        <= '0;
      cnt        <= '0;
      add_valid  <= 1'b0;
      add_amount <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_next;
      sel        <= sel_next;
      amt        <= amt_next;
      cnt        <= cnt_next;
      add_valid  <= valid_next;
      add_amount <= amount_next;
      busy       <= busy_next;
    end
  end

  // Next-state logic; outputs are derived from the next state so they are
  // registered in step with the state itself.
  always_comb begin
    state_next = state;
    sel_next   = sel;
    amt_next   = amt;
    cnt_next   = cnt;

    unique case (state)
      IDLE: begin
        if (any_btn) begin
          if (sync2[0]) begin
            sel_next = 4'b0001;
            amt_next = AMT_W'(50);
          end else if (sync2[1]) begin
            sel_next = 4'b0010;
            amt_next = AMT_W'(150);
          end else if (sync2[2]) begin
            sel_next = 4'b0100;
            amt_next = AMT_W'(200);
          end else begin
            sel_next = 4'b1000;
            amt_next = AMT_W'(500);
          end
          cnt_next   = '0;
          state_next = QUAL;
        end
      end

      QUAL: begin
        if (!sel_hit) begin
          state_next = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_next = FIRE;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end

      FIRE: begin
        if (add_valid && add_ready) begin
          cnt_next   = '0;
          state_next = RELEASE;
        end
      end

      RELEASE: begin
        // Any high button restarts the release qualification.
        if (any_btn) begin
          cnt_next = '0;
        end else if (cnt == CNT_LAST) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end

      default: state_next = IDLE;
    endcase

    valid_next  = (state_next == FIRE);
    amount_next = valid_next ? amt_next : '0;
    busy_next   = (state_next != IDLE);
  end

endmodule

// File: tb/tb_meter_coin_input.sv
// tb_meter_coin_input
// Directed bench for meter_coin_input with DEB_CYCLES = 4: a per-cycle vector
// table for the clean press and bounce traces, then hand-written sequences
// for backpressure, priority, reset and release qualification.
module tb_meter_coin_input;

  logic       clk;
  logic       reset10;
  logic       add50, add150, add200, add500;
  logic       add_ready;
  logic       add_valid;
  logic [9:0] add_amount;
  logic       busy;

  int unsigned n_pass;
  int unsigned n_total;

  meter_coin_input #(.DEB_CYCLES(4), .CNT_W(20)) dut (
    .clk        (clk),
    .reset10    (reset10),
    .add50      (add50),
    .add150     (add150),
    .add200     (add200),
    .add500     (add500),
    .add_ready  (add_ready),
    .add_valid  (add_valid),
    .add_amount (add_amount),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // btn order: {add500, add200, add150, add50}
  typedef struct {
    logic [3:0] btn;
    logic       ready;
    logic       valid;
    logic [9:0] amount;
    logic       busy;
  } vec_t;

  vec_t vq[$];

  function automatic void add_vec(input logic [3:0] b, input logic r, input logic v,
                                  input logic [9:0] a, input logic bz, input int n);
    vec_t e;
    e.btn = b; e.ready = r; e.valid = v; e.amount = a; e.busy = bz;
    for (int i = 0; i < n; i++) vq.push_back(e);
  endfunction

  task automatic check(input string name, input int idx, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
  endtask

  task automatic set_btn(input logic [3:0] b);
    add50  = b[0];
    add150 = b[1];
    add200 = b[2];
    add500 = b[3];
  endtask

  // Advance one rising edge and settle past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Tick until add_valid rises (bounded); check latency and amount.
  task automatic wait_credit(input string name, input int exp_amt, input int exp_ticks);
    int  t;
    bit  seen;
    t = 0;
    seen = 0;
    while (!seen && t < 30) begin
      tick();
      t++;
      if (add_valid) seen = 1;
    end
    check({name, "_latency"}, 0, seen ? t : -1, exp_ticks);
    check({name, "_amount"}, 0, int'(add_amount), exp_amt);
  endtask

  task automatic run_idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_pass  = 0;
    n_total = 0;
    set_btn(4'b0000);
    add_ready = 1'b0;
    reset10   = 1'b1;

    // Clean press of add150, held 20 cycles, ready tied high.
    add_vec(4'b0010, 1'b1, 1'b0, 10'd0,   1'b0, 2);
    add_vec(4'b0010, 1'b1, 1'b0, 10'd0,   1'b1, 4);
    add_vec(4'b0010, 1'b1, 1'b1, 10'd150, 1'b1, 1);
    add_vec(4'b0010, 1'b1, 1'b0, 10'd0,   1'b1, 13);
    add_vec(4'b0000, 1'b1, 1'b0, 10'd0,   1'b1, 5);
    add_vec(4'b0000, 1'b1, 1'b0, 10'd0,   1'b0, 3);
    // Bounce: add500 high 2 / low 1, five times, then low.
    for (int k = 0; k < 21; k++) begin
      logic r;
      logic bz;
      r  = (k < 15) && ((k % 3) != 2);
      bz = (k >= 2) && (k <= 16) && (((k - 2) % 3) != 2);
      add_vec({r, 3'b000}, 1'b1, 1'b0, 10'd0, bz, 1);
    end

    // Reset state.
    #12;
    check("rst_valid", 0, int'(add_valid), 0);
    check("rst_amount", 0, int'(add_amount), 0);
    check("rst_busy", 0, int'(busy), 0);
    @(negedge clk);
    reset10 = 1'b0;
    tick();

    // Table-driven traces.
    foreach (vq[i]) begin
      set_btn(vq[i].btn);
      add_ready = vq[i].ready;
      tick();
      check("vec_valid",  i, int'(add_valid),  int'(vq[i].valid));
      check("vec_amount", i, int'(add_amount), int'(vq[i].amount));
      check("vec_busy",   i, int'(busy),       int'(vq[i].busy));
    end

    // Backpressure: add200 held, ready low for 10 cycles.
    add_ready = 1'b0;
    set_btn(4'b0100);
    wait_credit("bp", 200, 7);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_hold_valid",  i, int'(add_valid), 1);
      check("bp_hold_amount", i, int'(add_amount), 200);
    end
    add_ready = 1'b1;
    tick();
    check("bp_xfer_valid", 0, int'(add_valid), 0);
    check("bp_xfer_amount", 0, int'(add_amount), 0);
    check("bp_xfer_busy", 0, int'(busy), 1);
    set_btn(4'b0000);
    run_idle(6);
    check("bp_idle_busy", 0, int'(busy), 0);

    // Priority: add50 and add500 together, then add500 alone.
    set_btn(4'b1001);
    wait_credit("prio50", 50, 7);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("prio_no_repeat", i, int'(add_valid), 0);
    end
    set_btn(4'b0000);
    run_idle(6);
    check("prio_idle_busy", 0, int'(busy), 0);
    set_btn(4'b1000);
    wait_credit("prio500", 500, 7);
    tick();
    set_btn(4'b0000);
    run_idle(6);

    // Reset while in FIRE with ready low, button held through reset.
    add_ready = 1'b0;
    set_btn(4'b0100);
    wait_credit("rst_pre", 200, 7);
    #2;
    reset10 = 1'b1;
    #1;
    check("rst_mid_valid", 0, int'(add_valid), 0);
    check("rst_mid_amount", 0, int'(add_amount), 0);
    check("rst_mid_busy", 0, int'(busy), 0);
    tick();
    reset10 = 1'b0;
    add_ready = 1'b1;
    wait_credit("rst_reissue", 200, 7);
    tick();
    set_btn(4'b0000);
    run_idle(6);
    check("rst_end_busy", 0, int'(busy), 0);

    // Release bounce after a credit, then a new add50 press.
    add_ready = 1'b1;
    set_btn(4'b0001);
    wait_credit("rel_first", 50, 7);
    for (int k = 0; k < 13; k++) begin
      set_btn({3'b000, (k == 2)});
      tick();
      check("rel_valid", k, int'(add_valid), 0);
      if (k == 7) check("rel_busy_before", k, int'(busy), 1);
      if (k == 8) check("rel_busy_after", k, int'(busy), 0);
    end
    set_btn(4'b0001);
    wait_credit("rel_second", 50, 7);
    tick();
    check("rel_second_drop", 0, int'(add_valid), 0);
    set_btn(4'b0000);
    run_idle(6);
    check("rel_end_busy", 0, int'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
